ex_operand_stage: RTL

- ID/EX pipeline register plus operand-select and forwarding logic sitting directly upstream of the ALU in the pipelined MIPS core.
- Captures decoded fields from ID each cycle and drives the ALU's reg_a, reg_b and ALUCr, together with the write-back fields the EX/MEM register needs.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/ex_operand_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX stage register with operand select and EX/MEM, MEM/WB forwarding for the ALU.
// Define EX_OPERAND_FORWARD_EN to enable forwarding; otherwise operands come straight from the register file.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_src_a,
  input  logic [1:0]        id_src_b,
  input  logic              id_reg_wen,
  input  logic              exm_wen,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wen,
  input  logic [RA_W-1:0]   mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic              ex_valid,
  output logic              ex_reg_wen,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_rt_fwd
);
  localparam logic [3:0] ALU_ADD = 4'b0010;

  logic              valid_q, valid_d;
  logic              reg_wen_q, reg_wen_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [RA_W-1:0]   rs_q, rs_d;
  logic [RA_W-1:0]   rt_q, rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [15:0]       imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              src_a_q, src_a_d;
  logic [1:0]        src_b_q, src_b_d;

  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // Flush wins over stall; a bubble zeroes register numbers and data so the ALU sees 0 + 0.
  always_comb begin
    valid_d   = valid_q;
    reg_wen_d = reg_wen_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    ctrl_d    = ctrl_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    if (flush) begin
      valid_d   = 1'b0;
      reg_wen_d = 1'b0;
      rd_d      = '0;
      rs_d      = '0;
      rt_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
      ctrl_d    = ALU_ADD;
      src_a_d   = 1'b0;
      src_b_d   = 2'd0;
    end else if (!stall) begin
      valid_d   = id_valid;
      reg_wen_d = id_reg_wen & id_valid;
      rd_d      = id_rd;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      shamt_d   = id_shamt;
      ctrl_d    = id_alu_ctrl;
      src_a_d   = id_src_a;
      src_b_d   = id_src_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      ctrl_q    <= ALU_ADD;
      src_a_q   <= 1'b0;
      src_b_q   <= 2'd0;
    end else begin
      valid_q   <= valid_d;
      reg_wen_q <= reg_wen_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      ctrl_q    <= ctrl_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
    end
  end

`ifdef EX_OPERAND_FORWARD_EN
  // Youngest producer (EX/MEM) wins; $zero is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [RA_W-1:0]   r,
    input logic [DATA_W-1:0] rf,
    input logic              e_wen,
    input logic [RA_W-1:0]   e_rd,
    input logic [DATA_W-1:0] e_data,
    input logic              m_wen,
    input logic [RA_W-1:0]   m_rd,
    input logic [DATA_W-1:0] m_data
  );
    if (e_wen && (e_rd != '0) && (e_rd == r))      return e_data;
    else if (m_wen && (m_rd != '0) && (m_rd == r)) return m_data;
    else                                           return rf;
  endfunction

  assign fwd_rs = fwd_pick(rs_q, rs_data_q, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
  assign fwd_rt = fwd_pick(rt_q, rt_data_q, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data, rs_q, rt_q};
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
`endif

  always_comb begin
    alu_a = src_a_q ? fwd_rt : fwd_rs;
    alu_b = fwd_rt;
    case (src_b_q)
      2'd0:    alu_b = fwd_rt;
      2'd1:    alu_b = {{(DATA_W-16){imm_q[15]}}, imm_q};
      2'd2:    alu_b = {{(DATA_W-16){1'b0}}, imm_q};
      default: alu_b = {{(DATA_W-5){1'b0}}, shamt_q};
    endcase
  end

  assign alu_ctrl   = ctrl_q;
  assign ex_valid   = valid_q;
  assign ex_reg_wen = reg_wen_q;
  assign ex_rd      = rd_q;
  assign ex_rt_fwd  = fwd_rt;

endmodule
